// File: rtl/counter_down_sync.sv
// Loadable synchronous down-counter / interval timer with one-shot and auto-reload modes.
// Define COUNTER_DOWN_PRESCALE_EN to divide enabled RUN cycles by PRESCALE before each decrement.
module counter_down_sync #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  // Handshake: none; load/start/stop are single-cycle pulses sampled on the rising edge,
  // with priority load > stop > start > count.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             tick;

`ifdef COUNTER_DOWN_PRESCALE_EN
  localparam int unsigned PSC_W = $clog2(PRESCALE);
  logic [PSC_W-1:0] psc;
  logic             psc_wrap;

  assign psc_wrap = (psc == PSC_W'(PRESCALE - 1));

  // Prescaler advances only on enabled RUN cycles that are not overridden by a control pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (stop) begin
      psc <= psc;
    end else if (start) begin
      if (state == IDLE && count != '0) psc <= '0;
    end else if (state == RUN && en) begin
      psc <= psc_wrap ? '0 : psc + PSC_W'(1);
    end
  end

  always_comb begin
    tick = 1'b0;
    if (!load && !stop && !start && state == RUN && en) tick = psc_wrap;
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);

  always_comb begin
    tick = 1'b0;
    if (!load && !stop && !start && state == RUN && en) tick = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count  <= load_val;
        reload <= load_val;
        state  <= IDLE;
      end else if (stop) begin
        if (state == RUN) state <= IDLE;
      end else if (start) begin
        if (state == IDLE && count != '0) state <= RUN;
      end else if (tick) begin
        // count==0 is never decremented, so the counter cannot wrap.
        if (count > WIDTH'(1)) begin
          count <= count - WIDTH'(1);
        end else if (count == WIDTH'(1)) begin
          tc <= 1'b1;
          if (mode) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_down_sync.sv
// Directed self-checking bench for counter_down_sync; expected {tc,busy,count} per cycle
// come from hand-computed vectors held in an expected queue.
module tb_counter_down_sync;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic         start;
  logic         stop;
  logic         en;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;

  int total;
  int bad;
  logic [W+1:0] exp_q[$];

  counter_down_sync #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .tc       (tc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push(input logic t, input logic b, input logic [W-1:0] c);
    exp_q.push_back({t, b, c});
  endtask

  // scoreboard: one expected {tc,busy,count} per clock
  task automatic drain(input string tag);
    logic [W+1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check({tag, ".count"}, 32'(count), 32'(e[W-1:0]));
      check({tag, ".busy"},  32'(busy),  32'(e[W]));
      check({tag, ".tc"},    32'(tc),    32'(e[W+1]));
    end
  endtask

  initial begin
    logic [W-1:0] exp_c [5];
    total = 0; bad = 0;
    rst_n = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0;
    start = 1'b0; stop = 1'b0; en = 1'b0;
    #1;
    check("reset.count", 32'(count), 0);
    check("reset.busy",  32'(busy),  0);
    check("reset.tc",    32'(tc),    0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // async reset in the middle of RUN
    mode = 1'b0; en = 1'b0;
    do_load(4'd3);
    do_start();
    check("arst.pre_busy", 32'(busy), 1);
    check("arst.pre_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.busy",  32'(busy),  0);
    check("arst.tc",    32'(tc),    0);
    tick();
    rst_n = 1'b1;
    tick();

    // one-shot count 5 -> 0
    mode = 1'b0; en = 1'b1;
    do_load(4'd5);
    check("oneshot.load_count", 32'(count), 5);
    check("oneshot.load_busy",  32'(busy),  0);
    do_start();
    check("oneshot.start_count", 32'(count), 5);
    check("oneshot.start_busy",  32'(busy),  1);
    push(0, 1, 4); push(0, 1, 3); push(0, 1, 2); push(0, 1, 1);
    push(1, 0, 0); push(0, 0, 0); push(0, 0, 0);
    drain("oneshot");

    // auto-reload period 3
    mode = 1'b1; en = 1'b1;
    do_load(4'd3);
    do_start();
    check("reload.start_busy", 32'(busy), 1);
    push(0, 1, 2); push(0, 1, 1); push(1, 1, 3);
    push(0, 1, 2); push(0, 1, 1); push(1, 1, 3); push(0, 1, 2);
    drain("reload");
    do_stop();
    check("reload.stop_count", 32'(count), 2);
    check("reload.stop_busy",  32'(busy),  0);

    // enable gating, pause and resume
    mode = 1'b0; en = 1'b0;
    do_load(4'd6);
    do_start();
    check("pause.start_count", 32'(count), 6);
    exp_c[0] = 5; exp_c[1] = 5; exp_c[2] = 4; exp_c[3] = 4; exp_c[4] = 3;
    for (int i = 0; i < 5; i++) begin
      en = (i % 2 == 0);
      tick();
      check("pause.en_count", 32'(count), 32'(exp_c[i]));
    end
    en = 1'b1;
    do_stop();
    check("pause.stop_count", 32'(count), 3);
    check("pause.stop_busy",  32'(busy),  0);
    push(0, 0, 3); push(0, 0, 3); push(0, 0, 3); push(0, 0, 3);
    drain("pause.idle");
    do_start();
    check("pause.resume_busy",  32'(busy),  1);
    check("pause.resume_count", 32'(count), 3);
    push(0, 1, 2); push(0, 1, 1); push(1, 0, 0); push(0, 0, 0);
    drain("pause.resume");

    // control priority corners
    en = 1'b1; mode = 1'b0;
    load = 1'b1; load_val = 4'd7; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check("prio.loadstart_count", 32'(count), 7);
    check("prio.loadstart_busy",  32'(busy),  0);
    tick();
    check("prio.loadstart_idle", 32'(busy), 0);
    do_start();
    tick();
    check("prio.run_count", 32'(count), 6);
    do_load(4'd9);
    check("prio.load_run_count", 32'(count), 9);
    check("prio.load_run_busy",  32'(busy),  0);
    check("prio.load_run_tc",    32'(tc),    0);
    do_start();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("prio.stopstart_busy",  32'(busy),  0);
    check("prio.stopstart_count", 32'(count), 9);
    do_load(4'd0);
    do_start();
    check("prio.zero_start_busy", 32'(busy), 0);
    tick();
    check("prio.zero_start_count", 32'(count), 0);

`ifdef COUNTER_DOWN_PRESCALE_EN
    // PRESCALE=4: 2->1 after 4 enabled cycles, 1->0 with tc after 8
    mode = 1'b0; en = 1'b1;
    do_load(4'd2);
    do_start();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("psc.count", 32'(count), (i < 4) ? 2 : ((i < 8) ? 1 : 0));
      check("psc.tc",    32'(tc),    (i == 8) ? 1 : 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
